// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Half-periods are sanitised on a 32-bit carrier, so CNT_W must not exceed 32.
package clock_divider_pkg;

  localparam int CNT_W_DEF        = 28;
  localparam int DEFAULT_HALF_DEF = 100000;
  localparam int SAN_W            = 32;

  // A half-period of zero would never reach terminal count, so it is promoted to one.
  function automatic logic [SAN_W-1:0] sanitize_half(input logic [SAN_W-1:0] half);
    return (half == 32'd0) ? 32'd1 : half;
  endfunction

  // Channel selector width; a single channel still needs a one-bit selector.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_div_channel.sv
// One divider channel: half-period counter, active/pending half-period and
// registered 50%-duty output with a rising-edge tick.
module div_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             load_now,
  input  logic [CNT_W-1:0] load_half,
  output logic             pend_flag,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] act_r;
  logic [CNT_W-1:0] pend_r;
  logic             pf_r;
  logic             clk_r;
  logic             tick_r;
  logic             terminal_s;

  assign terminal_s = (cnt_r == (act_r - ONE));

  // Counter, half-period registers and divided clock; restart wins over terminal count.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      act_r  <= DEF_HALF;
      pend_r <= DEF_HALF;
      pf_r   <= 1'b0;
      clk_r  <= 1'b0;
      tick_r <= 1'b0;
    end else if (load && load_now) begin
      act_r  <= load_half;
      pf_r   <= 1'b0;
      cnt_r  <= '0;
      clk_r  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      if (!en) begin
        cnt_r  <= '0;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
        if (pf_r) begin
          act_r <= pend_r;
          pf_r  <= 1'b0;
        end
      end else if (terminal_s) begin
        cnt_r  <= '0;
        clk_r  <= ~clk_r;
        tick_r <= ~clk_r;
        if (pf_r) begin
          act_r <= pend_r;
          pf_r  <= 1'b0;
        end
      end else begin
        cnt_r  <= cnt_r + ONE;
        tick_r <= 1'b0;
      end
      // A deferred request is only accepted while pf_r is clear, so it never races the hand-over.
      if (load) begin
        pend_r <= load_half;
        pf_r   <= 1'b1;
      end
    end
  end

  assign pend_flag = pf_r;
  assign clk_out   = clk_r;
  assign tick      = tick_r;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: decodes the configuration port into
// per-channel load strobes and instantiates one div_channel per output.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_half,
  input  logic                        cfg_now,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [CNT_W-1:0]  half_s;
  logic [NUM_CH-1:0] pf_s;
  logic [NUM_CH-1:0] busy_s;
  logic [NUM_CH-1:0] load_s;

  assign half_s = CNT_W'(sanitize_half(SAN_W'(cfg_half)));

  // Out-of-range selectors match no channel, so they are always ready and silently dropped.
  assign cfg_ready = ~|busy_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign busy_s[i] = (cfg_ch == CH_W'(i)) & pf_s[i];
    assign load_s[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

    div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_div_channel (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en[i]),
      .load      (load_s[i]),
      .load_now  (cfg_now),
      .load_half (half_s),
      .pend_flag (pf_s[i]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i])
    );
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel successor to the single fixed divider used for game timing. Each of NUM_CH channels divides clk_in by a runtime-programmable even ratio (2 × half-period), producing a 50%-duty divided clock and a one-cycle tick on its rising edge. Divisors load through a valid/ready port, either glitch-free at the next terminal count or immediately with phase restart. It sits at the top level and feeds frame, animation and input-debounce logic.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- CNT_W, 28: counter / half-period width
- DEFAULT_HALF, 100000: reset half-period of every channel, in clk_in cycles
- clk_in  in  1  system clock; all logic on posedge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_half  in  CNT_W  new half-period; 0 treated as 1
- cfg_now  in  1  1 = apply immediately, 0 = apply at next terminal count
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse, asserted in the cycle clk_out[i] goes 0→1

## Operation
- Per channel: cnt, active half (act), pending half (pend), pending flag (pf), clk_out, tick.
- Running (en=1): cnt counts 0..act−1; at cnt==act−1: cnt←0, clk_out toggles, tick←1 if clk_out was 0; otherwise cnt+1, tick←0.
- Terminal count with pf=1: act←pend, pf←0 in same edge; toggle still occurs; new period counts from 0.
- Disabled (en=0): cnt←0, clk_out←0, tick←0; if pf=1, act←pend, pf←0 at next edge.
- Config accept, cfg_now=0: pend←max(cfg_half,1), pf←1.
- Config accept, cfg_now=1: act←max(cfg_half,1), pf←0, cnt←0, clk_out←0, tick←0 (no tick from restart).
- cfg_ready = ~pf[cfg_ch] (combinational on cfg_ch); cfg_ch ≥ NUM_CH: cfg_ready=1, request accepted and ignored.
- Terminal count and accepted cfg_now=0 on same channel same edge: act takes old pend (if pf) — cannot happen since cfg_ready=0 when pf; with pf=0, act unchanged, new request becomes pending.
- Terminal count and accepted cfg_now=1 same edge: immediate restart wins; no toggle, no tick.
- act=1: clk_out toggles every cycle, tick every 2nd cycle.
- Counter wraps never: cnt ≤ act−1 < 2^CNT_W.

## Timing
- Reset (async assert, sync release): cnt=0, act=DEFAULT_HALF, pf=0, clk_out=0, tick=0, cfg_ready=1.
- First clk_out rise after release/enable/restart: at edge number act (counting first running edge as 1); tick high for exactly that cycle.
- Period 2·act cycles, high time act cycles, exactly 50%.
- Deferred update latency: ≤ act_old cycles; immediate update: visible next edge.
- Reset mid-period: outputs to reset values instantly, pending config discarded.

## Structure
- Package clock_divider_pkg: CNT_W default, DEFAULT_HALF, helper for sanitising half (0→1), channel-index width function.
- Sub-module div_channel: one channel (cnt, act, pend, pf, clk_out, tick); top instantiates NUM_CH via generate and decodes cfg_ch to per-channel load strobes; top holds only cfg_ready mux.
- No clock gating; clk_out is a data signal — downstream uses tick as enable, not clk_out as clock.

## Test plan
- NUM_CH=2, DEFAULT_HALF=4, en=11 after reset → clk_out[0] rises at edge 4, falls at 8, rises at 12; tick high only at edges 4, 12.
- Deferred load ch0 half=2 at edge 2 → cfg_ready low until edge 4 toggle, then period 4 (rise at 4, fall 6, rise 8); ch1 unaffected.
- Immediate load ch1 half=3 mid-high-phase → next edge clk_out[1]=0, no tick; rise 3 edges later.
- cfg_half=0 → behaves as 1: clk_out toggles every cycle, tick every 2 cycles.
- en[0] dropped mid-period, pending load queued → clk_out[0]=0 next edge, pend applied; re-enable → first rise after new half.
- rst_n asserted mid-period with pf=1 → outputs 0 asynchronously, cfg_ready=1, act back to 4 after release.
